// File: rtl/bridge_pkg.sv
// Shared address map, decode select type and segment encoder
// for the CPU-side memory-mapped peripheral bridge.
package bridge_pkg;

    localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_DIG    = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TIMER  = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_TDIV   = 32'hFFFF_F024;
    localparam logic [31:0] ADDR_LED    = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW     = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN    = 32'hFFFF_F078;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_DIG,
        SEL_TIM,
        SEL_TDIV,
        SEL_LED,
        SEL_SW,
        SEL_BTN,
        SEL_NONE
    } sel_e;

    function automatic sel_e decode(input logic [31:0] addr);
        sel_e s;
        if (addr < PERIPH_BASE) begin
            s = SEL_RAM;
        end else begin
            case (addr)
                ADDR_DIG:   s = SEL_DIG;
                ADDR_TIMER: s = SEL_TIM;
                ADDR_TDIV:  s = SEL_TDIV;
                ADDR_LED:   s = SEL_LED;
                ADDR_SW:    s = SEL_SW;
                ADDR_BTN:   s = SEL_BTN;
                default:    s = SEL_NONE;
            endcase
        end
        return s;
    endfunction

    // Active-low {a,b,c,d,e,f,g,dp}; dp stays off.
    function automatic logic [7:0] hex7seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'h03;
            4'h1: s = 8'h9F;
            4'h2: s = 8'h25;
            4'h3: s = 8'h0D;
            4'h4: s = 8'h99;
            4'h5: s = 8'h49;
            4'h6: s = 8'h41;
            4'h7: s = 8'h1F;
            4'h8: s = 8'h01;
            4'h9: s = 8'h09;
            4'hA: s = 8'h11;
            4'hB: s = 8'hC1;
            4'hC: s = 8'h63;
            4'hD: s = 8'h85;
            4'hE: s = 8'h61;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bus_bridge_digit_scanner.sv
// Time-multiplexed driver for the 8-digit seven-segment display.
// Each digit is lit for SCAN_DIV clocks, digit 0 first.
module digit_scanner
    import bridge_pkg::*;
#(
    parameter int SCAN_DIV = 20000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] dig,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign dig_en  = ~(8'b1 << idx_q);
    assign dig_seg = hex7seg(dig[{idx_q, 2'b00} +: 4]);

endmodule

// File: rtl/bus_bridge.sv
// Decodes CPU data-bus accesses to RAM or on-chip peripherals
// and returns read data combinationally in the same cycle.
module bus_bridge
    import bridge_pkg::*;
#(
    parameter int SCAN_DIV    = 20000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_we,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    sel_e sel;

    logic [23:0] led_q, led_d;
    logic [31:0] dig_q, dig_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] tdiv_q, tdiv_d;
    logic [31:0] presc_q, presc_d;
    logic        tick;

    logic [SYNC_STAGES-1:0][23:0] sw_sync_q, sw_sync_d;
    logic [SYNC_STAGES-1:0][4:0]  btn_sync_q, btn_sync_d;

    assign sel        = decode(Bus_addr);
    assign dram_addr  = Bus_addr[15:2];
    assign dram_we    = Bus_wen && (sel == SEL_RAM);
    assign dram_wdata = Bus_wdata;
    assign led        = led_q;

    // Divider of zero freezes both the prescaler and the value.
    assign tick = (tdiv_q != 32'd0) && (presc_q == tdiv_q - 32'd1);

    always_comb begin
        led_d      = led_q;
        dig_d      = dig_q;
        tval_d     = tick ? tval_q + 32'd1 : tval_q;
        tdiv_d     = tdiv_q;
        presc_d    = presc_q;
        sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], sw};
        btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], btn};
        if (tdiv_q != 32'd0) begin
            presc_d = tick ? 32'd0 : presc_q + 32'd1;
        end
        if (Bus_wen) begin
            unique case (sel)
                SEL_DIG:  dig_d = Bus_wdata;
                SEL_LED:  led_d = Bus_wdata[23:0];
                SEL_TIM:  tval_d = Bus_wdata;
                SEL_TDIV: begin
                    tdiv_d  = Bus_wdata;
                    presc_d = 32'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            led_q      <= '0;
            dig_q      <= '0;
            tval_q     <= '0;
            tdiv_q     <= '0;
            presc_q    <= '0;
            sw_sync_q  <= '0;
            btn_sync_q <= '0;
        end else begin
            led_q      <= led_d;
            dig_q      <= dig_d;
            tval_q     <= tval_d;
            tdiv_q     <= tdiv_d;
            presc_q    <= presc_d;
            sw_sync_q  <= sw_sync_d;
            btn_sync_q <= btn_sync_d;
        end
    end

    always_comb begin
        Bus_rdata = 32'd0;
        unique case (sel)
            SEL_RAM:  Bus_rdata = dram_rdata;
            SEL_DIG:  Bus_rdata = dig_q;
            SEL_TIM:  Bus_rdata = tval_q;
            SEL_TDIV: Bus_rdata = tdiv_q;
            SEL_LED:  Bus_rdata = {8'd0, led_q};
            SEL_SW:   Bus_rdata = {8'd0, sw_sync_q[SYNC_STAGES-1]};
            SEL_BTN:  Bus_rdata = {27'd0, btn_sync_q[SYNC_STAGES-1]};
            default:  Bus_rdata = 32'd0;
        endcase
    end

    digit_scanner #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .cpu_clk(cpu_clk),
        .cpu_rst(cpu_rst),
        .dig    (dig_q),
        .dig_en (dig_en),
        .dig_seg(dig_seg)
    );

endmodule

// File: tb/tb_bus_bridge.sv
// Directed and randomized bench for bus_bridge against a
// cycle-count based reference model of the peripheral map.
module tb_bus_bridge;

    localparam int SD = 4;
    localparam int SS = 2;

    localparam logic [31:0] A_DIG  = 32'hFFFF_F000;
    localparam logic [31:0] A_TIM  = 32'hFFFF_F020;
    localparam logic [31:0] A_TDIV = 32'hFFFF_F024;
    localparam logic [31:0] A_LED  = 32'hFFFF_F060;
    localparam logic [31:0] A_SW   = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN  = 32'hFFFF_F078;
    localparam logic [31:0] A_UNM  = 32'hFFFF_F040;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b0;
    logic [31:0] Bus_addr = '0;
    logic        Bus_wen = 1'b0;
    logic [31:0] Bus_wdata = '0;
    logic [31:0] Bus_rdata;
    logic [13:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata = '0;
    logic [23:0] sw = '0;
    logic [4:0]  btn = '0;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  dig_seg;

    bus_bridge #(
        .SCAN_DIV(SD),
        .SYNC_STAGES(SS)
    ) dut (
        .cpu_clk(cpu_clk),
        .cpu_rst(cpu_rst),
        .Bus_addr(Bus_addr),
        .Bus_wen(Bus_wen),
        .Bus_wdata(Bus_wdata),
        .Bus_rdata(Bus_rdata),
        .dram_addr(dram_addr),
        .dram_we(dram_we),
        .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata),
        .sw(sw),
        .btn(btn),
        .led(led),
        .dig_en(dig_en),
        .dig_seg(dig_seg)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_pass = 0;
    int n_chk  = 0;

    logic [7:0] seg_tab [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    logic [23:0] m_led;
    logic [31:0] m_dig, m_tval, m_tdiv, m_presc;
    int          m_cyc;
    logic [23:0] sw_hist [$];
    logic [4:0]  btn_hist [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_led = '0; m_dig = '0; m_tval = '0; m_tdiv = '0;
        m_presc = '0; m_cyc = 0;
        sw_hist.delete(); btn_hist.delete();
        for (int i = 0; i < SS; i++) begin
            sw_hist.push_back('0);
            btn_hist.push_back('0);
        end
    endtask

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        if (a < 32'hFFFF_F000) return dram_rdata;
        case (a)
            A_DIG:  return m_dig;
            A_TIM:  return m_tval;
            A_TDIV: return m_tdiv;
            A_LED:  return {8'd0, m_led};
            A_SW:   return {8'd0, sw_hist[0]};
            A_BTN:  return {27'd0, btn_hist[0]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_all();
        int idx;
        logic [31:0] nib;
        idx = (m_cyc / SD) % 8;
        nib = (m_dig >> (4 * idx)) & 32'hF;
        chk("rdata", Bus_rdata, exp_rdata(Bus_addr));
        chk("dram_we", {31'd0, dram_we},
            {31'd0, Bus_wen && (Bus_addr < 32'hFFFF_F000)});
        chk("dram_addr", {18'd0, dram_addr}, {18'd0, Bus_addr[15:2]});
        chk("dram_wdata", dram_wdata, Bus_wdata);
        chk("led", {8'd0, led}, {8'd0, m_led});
        chk("dig_en", {24'd0, dig_en}, {24'd0, ~(8'd1 << idx)});
        chk("dig_seg", {24'd0, dig_seg}, {24'd0, seg_tab[nib[3:0]]});
    endtask

    // One clock edge; model advances only when out of reset.
    task automatic cyc();
        logic        run, tick;
        logic [31:0] n_tval, n_tdiv, n_presc, n_dig;
        logic [23:0] n_led;
        run = cpu_rst;
        tick = (m_tdiv != 0) && (m_presc == m_tdiv - 1);
        n_tval = m_tval + (tick ? 32'd1 : 32'd0);
        n_tdiv = m_tdiv;
        n_presc = (m_tdiv == 0) ? m_presc : (tick ? 32'd0 : m_presc + 1);
        n_led = m_led;
        n_dig = m_dig;
        if (Bus_wen) begin
            if (Bus_addr == A_TIM) n_tval = Bus_wdata;
            if (Bus_addr == A_TDIV) begin
                n_tdiv = Bus_wdata;
                n_presc = 0;
            end
            if (Bus_addr == A_LED) n_led = Bus_wdata[23:0];
            if (Bus_addr == A_DIG) n_dig = Bus_wdata;
        end
        @(posedge cpu_clk);
        #1;
        if (run) begin
            m_tval = n_tval; m_tdiv = n_tdiv; m_presc = n_presc;
            m_led = n_led; m_dig = n_dig; m_cyc++;
            sw_hist.push_back(sw);  void'(sw_hist.pop_front());
            btn_hist.push_back(btn); void'(btn_hist.pop_front());
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic w,
                         input logic [31:0] d);
        Bus_addr = a; Bus_wen = w; Bus_wdata = d;
        #1;
        check_all();
        cyc();
    endtask

    initial begin
        int guard;
        logic [31:0] a, d;
        model_reset();
        Bus_addr = A_TIM;
        #2;
        check_all();
        repeat (2) @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b1;

        // RAM passthrough
        Bus_addr = 32'h0000_0104; Bus_wen = 1'b1; Bus_wdata = 32'hDEADBEEF;
        dram_rdata = 32'h1234_5678;
        #1;
        chk("ram_we", {31'd0, dram_we}, 32'd1);
        chk("ram_addr", {18'd0, dram_addr}, 32'h041);
        chk("ram_rd", Bus_rdata, 32'h1234_5678);
        drive(32'h0000_0104, 1'b1, 32'hDEADBEEF);
        Bus_addr = A_LED; Bus_wen = 1'b1; Bus_wdata = 32'hFFA5A5A5;
        #1;
        chk("periph_we", {31'd0, dram_we}, 32'd0);
        cyc();

        // LED / SW / BTN
        drive(A_LED, 1'b0, 32'h0);
        chk("led_val", {8'd0, led}, 32'h00A5_A5A5);
        chk("led_rd", Bus_rdata, 32'h00A5_A5A5);
        sw = 24'h00F00F; btn = 5'h15;
        drive(A_SW, 1'b0, 0);
        drive(A_SW, 1'b0, 0);
        chk("sw_sync", Bus_rdata, 32'h0000_F00F);
        drive(A_SW, 1'b1, 32'h1111_1111);
        drive(A_BTN, 1'b1, 32'h1F);
        drive(A_SW, 1'b0, 0);
        chk("sw_ro", Bus_rdata, 32'h0000_F00F);
        drive(A_BTN, 1'b0, 0);

        // Timer
        drive(A_TDIV, 1'b1, 32'd3);
        for (int i = 0; i < 9; i++) drive(A_TIM, 1'b0, 0);
        chk("tim_3x3", m_tval, 32'd3);
        drive(A_TIM, 1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) drive(A_TIM, 1'b0, 0);
        drive(A_TDIV, 1'b1, 32'd0);
        for (int i = 0; i < 6; i++) drive(A_TIM, 1'b0, 0);
        drive(A_TDIV, 1'b1, 32'd3);
        guard = 0;
        while (m_presc != m_tdiv - 1 && guard < 10) begin
            drive(A_TIM, 1'b0, 0);
            guard++;
        end
        chk("tick_found", guard < 10 ? 32'd1 : 32'd0, 32'd1);
        drive(A_TIM, 1'b1, 32'h0000_ABCD);
        Bus_wen = 1'b0; #1;
        chk("tick_wr", Bus_rdata, 32'h0000_ABCD);

        // Display
        drive(A_DIG, 1'b1, 32'h7654_3210);
        for (int i = 0; i < 40; i++) drive(A_DIG, 1'b0, 0);

        // Unmapped
        drive(A_UNM, 1'b1, 32'hFFFF_FFFF);
        drive(32'hFFFF_FFFC, 1'b1, 32'h1234_5678);
        drive(A_UNM, 1'b0, 0);

        // Mid-run asynchronous reset
        drive(A_TIM, 1'b0, 0);
        cpu_rst = 1'b0;
        model_reset();
        #1;
        chk("rst_led", {8'd0, led}, 32'd0);
        chk("rst_en", {24'd0, dig_en}, 32'hFE);
        chk("rst_seg", {24'd0, dig_seg}, 32'h03);
        chk("rst_tim", Bus_rdata, 32'd0);
        drive(A_LED, 1'b1, 32'h00FF_FFFF);
        drive(A_DIG, 1'b0, 0);
        cpu_rst = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0: a = $urandom_range(0, 32'hFFFF_EFFF) & 32'hFFFF_FFFC;
                1: a = A_DIG;
                2: a = A_TIM;
                3: a = A_TDIV;
                4: a = A_LED;
                5: a = A_SW;
                6: a = A_BTN;
                7: a = A_UNM;
                8: a = 32'hFFFF_FFFC;
                default: a = 32'hFFFF_EFFC;
            endcase
            d = (a == A_TDIV) ? 32'($urandom_range(0, 4)) : $urandom;
            dram_rdata = $urandom;
            sw = 24'($urandom);
            btn = 5'($urandom);
            drive(a, 1'($urandom_range(0, 1)), d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
